// File: rtl/tank_bullet_pool_if.sv
// Purpose: player key/collision inputs and tank + bullet-pool state outputs, bundled per frame.
// Latency: pure wiring; the pool registers everything it drives onto this bundle.
// Backpressure: none; the pool consumes one keycode/hit_clear sample every frame.
interface tank_bullet_pool_if #(
  parameter int NUM_BULLETS = 4
);
  logic [7:0]               keycode;
  logic [NUM_BULLETS-1:0]   hit_clear;
  logic [9:0]               tank_x;
  logic [9:0]               tank_y;
  logic [3:0]               tank_dir;
  logic [NUM_BULLETS-1:0]   bullet_active;
  logic [10*NUM_BULLETS-1:0] bullet_x;
  logic [10*NUM_BULLETS-1:0] bullet_y;
  logic [4*NUM_BULLETS-1:0] bullet_dir;
  logic                     fire_event;

  // Keyboard / collision side.
  modport master (
    output keycode, hit_clear,
    input  tank_x, tank_y, tank_dir, bullet_active, bullet_x, bullet_y, bullet_dir, fire_event
  );

  // Tank and bullet pool side.
  modport slave (
    input  keycode, hit_clear,
    output tank_x, tank_y, tank_dir, bullet_active, bullet_x, bullet_y, bullet_dir, fire_event
  );
endinterface

// File: rtl/tank_bullet_pool.sv
// Purpose: tank movement plus a fixed pool of bullet slots with shot cooldown; define TANK_AUTOFIRE_EN for held-key repeat fire.
// Latency: all outputs registered; inputs sampled in frame N are reflected on the outputs right after that frame's edge.
// Backpressure: none; a shot that cannot be placed (cooldown, full pool, off-field spawn) is dropped, never queued.
module tank_bullet_pool #(
  parameter int NUM_BULLETS  = 4,
  parameter int STEP         = 2,
  parameter int BULLET_SPEED = 4,
  parameter int COOLDOWN     = 8,
  parameter int X_MIN        = 80,
  parameter int X_MAX        = 527,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 447,
  parameter int X_RESET      = 320,
  parameter int Y_RESET      = 240
) (
  input  logic              frame_clk,
  input  logic              Reset,
  tank_bullet_pool_if.slave bus
);

  localparam logic [7:0] KEY_UP    = 8'h1A;
  localparam logic [7:0] KEY_DOWN  = 8'h16;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;
  localparam logic [7:0] KEY_FIRE  = 8'h2C;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  // Candidate positions are computed in 12-bit signed so that e.g. y-4 at y=2
  // becomes negative and fails the bounds test instead of wrapping to ~1020.
  typedef logic signed [11:0] coord_t;

  localparam coord_t XMIN_S  = coord_t'(X_MIN);
  localparam coord_t XMAX_S  = coord_t'(X_MAX);
  localparam coord_t YMIN_S  = coord_t'(Y_MIN);
  localparam coord_t YMAX_S  = coord_t'(Y_MAX);
  localparam coord_t STEP_S  = coord_t'(STEP);
  localparam coord_t SPEED_S = coord_t'(BULLET_SPEED);

  typedef struct packed {
    logic       active;
    logic [3:0] dir;
    logic [9:0] x;
    logic [9:0] y;
  } bullet_t;

  function automatic coord_t widen(input logic [9:0] v);
    return $signed({2'b00, v});
  endfunction

  function automatic logic in_field(input coord_t x, input coord_t y);
    return (x >= XMIN_S) && (x <= XMAX_S) && (y >= YMIN_S) && (y <= YMAX_S);
  endfunction

  // One frame of flight for a live bullet: move it, or retire it in place if
  // the next point would leave the field.
  function automatic bullet_t advance(input bullet_t b);
    coord_t  nx;
    coord_t  ny;
    bullet_t r;
    nx = widen(b.x);
    ny = widen(b.y);
    case (b.dir)
      DIR_DOWN:  ny = ny + SPEED_S;
      DIR_LEFT:  nx = nx - SPEED_S;
      DIR_RIGHT: nx = nx + SPEED_S;
      default:   ny = ny - SPEED_S;
    endcase
    r = b;
    if (in_field(nx, ny)) begin
      r.x = nx[9:0];
      r.y = ny[9:0];
    end else begin
      r.active = 1'b0;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  logic [9:0]      tank_x_q;
  logic [9:0]      tank_y_q;
  logic [3:0]      tank_dir_q;
  logic [CD_W-1:0] cd_q;
  logic            prev_fire_q;
  logic            fire_event_q;
  bullet_t         slot_q   [NUM_BULLETS];
  bullet_t         slot_nxt [NUM_BULLETS];

  // ---------------------------------------------------------------- tank
  coord_t     tank_mx;
  coord_t     tank_my;
  logic [3:0] tank_dir_nxt;
  logic [9:0] tank_x_nxt;
  logic [9:0] tank_y_nxt;

  // Candidate move from the key; the facing turns even if the move is refused.
  always_comb begin
    tank_dir_nxt = tank_dir_q;
    tank_mx      = widen(tank_x_q);
    tank_my      = widen(tank_y_q);
    case (bus.keycode)
      KEY_UP: begin
        tank_dir_nxt = DIR_UP;
        tank_my      = widen(tank_y_q) - STEP_S;
      end
      KEY_DOWN: begin
        tank_dir_nxt = DIR_DOWN;
        tank_my      = widen(tank_y_q) + STEP_S;
      end
      KEY_LEFT: begin
        tank_dir_nxt = DIR_LEFT;
        tank_mx      = widen(tank_x_q) - STEP_S;
      end
      KEY_RIGHT: begin
        tank_dir_nxt = DIR_RIGHT;
        tank_mx      = widen(tank_x_q) + STEP_S;
      end
      default: ;
    endcase
    if (in_field(tank_mx, tank_my)) begin
      tank_x_nxt = tank_mx[9:0];
      tank_y_nxt = tank_my[9:0];
    end else begin
      tank_x_nxt = tank_x_q;
      tank_y_nxt = tank_y_q;
    end
  end

  // ---------------------------------------------------------------- fire request
  logic fire_key;
  logic fire_req;

  assign fire_key = (bus.keycode == KEY_FIRE);

`ifdef TANK_AUTOFIRE_EN
  // Held fire key asks for a shot every frame; cooldown sets the repeat rate.
  assign fire_req = fire_key;
`else
  // Only the press edge asks for a shot; prev_fire_q comes out of reset set so
  // a key already held at reset must be released first.
  assign fire_req = fire_key && !prev_fire_q;
`endif

  // ---------------------------------------------------------------- spawn point
  coord_t spawn_x;
  coord_t spawn_y;

  // Just outside the 32x32 tank body, centred on the side it faces, from the pre-move position.
  always_comb begin
    spawn_x = widen(tank_x_q) + coord_t'(12);
    spawn_y = widen(tank_y_q) + coord_t'(12);
    case (tank_dir_q)
      DIR_DOWN:  spawn_y = widen(tank_y_q) + coord_t'(32);
      DIR_LEFT:  spawn_x = widen(tank_x_q) - coord_t'(8);
      DIR_RIGHT: spawn_x = widen(tank_x_q) + coord_t'(32);
      default:   spawn_y = widen(tank_y_q) - coord_t'(8);
    endcase
  end

  // ---------------------------------------------------------------- slot allocation
  logic [NUM_BULLETS-1:0] pick_vec;
  logic                   picked;
  logic                   shot_ok;

  // Lowest-index slot already free at the start of the frame; a slot being
  // retired this frame is still active here, so it cannot be reused until next frame.
  always_comb begin
    pick_vec = '0;
    picked   = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!slot_q[i].active && !picked) begin
        pick_vec[i] = 1'b1;
        picked      = 1'b1;
      end
    end
  end

  assign shot_ok = fire_req && (cd_q == '0) && picked && in_field(spawn_x, spawn_y);

  // Per slot: load a new shot, honour a kill request, or fly/retire the bullet.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      slot_nxt[i] = slot_q[i];
      if (!slot_q[i].active) begin
        if (shot_ok && pick_vec[i]) begin
          slot_nxt[i] = '{active: 1'b1, dir: tank_dir_q, x: spawn_x[9:0], y: spawn_y[9:0]};
        end
      end else if (bus.hit_clear[i]) begin
        slot_nxt[i].active = 1'b0;
      end else begin
        slot_nxt[i] = advance(slot_q[i]);
      end
    end
  end

  // ---------------------------------------------------------------- registers
  // Frame-rate state update; Reset wins over any move, shot or hit in the same frame.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      tank_x_q     <= 10'(X_RESET);
      tank_y_q     <= 10'(Y_RESET);
      tank_dir_q   <= DIR_UP;
      cd_q         <= '0;
      prev_fire_q  <= 1'b1;
      fire_event_q <= 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        slot_q[i] <= '{active: 1'b0, dir: DIR_UP, x: 10'd0, y: 10'd0};
      end
    end else begin
      tank_x_q     <= tank_x_nxt;
      tank_y_q     <= tank_y_nxt;
      tank_dir_q   <= tank_dir_nxt;
      prev_fire_q  <= fire_key;
      fire_event_q <= shot_ok;
      if (shot_ok) begin
        cd_q <= CD_W'(COOLDOWN);
      end else if (cd_q != '0) begin
        cd_q <= cd_q - CD_W'(1);
      end
      for (int i = 0; i < NUM_BULLETS; i++) begin
        slot_q[i] <= slot_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.tank_x     = tank_x_q;
  assign bus.tank_y     = tank_y_q;
  assign bus.tank_dir   = tank_dir_q;
  assign bus.fire_event = fire_event_q;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_out
    assign bus.bullet_active[g]       = slot_q[g].active;
    assign bus.bullet_x[10*g +: 10]   = slot_q[g].x;
    assign bus.bullet_y[10*g +: 10]   = slot_q[g].y;
    assign bus.bullet_dir[4*g +: 4]   = slot_q[g].dir;
  end

endmodule

// File: tb/tb_tank_bullet_pool.sv
// Bench for tank_bullet_pool: directed scenarios then random key/hit traffic,
// every frame checked against a behavioural model of the game rules.
module tb_tank_bullet_pool;
  localparam int NB   = 4;
  localparam int XMIN = 80;
  localparam int XMAX = 527;
  localparam int YMIN = 0;
  localparam int YMAX = 447;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;

  tank_bullet_pool_if #(.NUM_BULLETS(NB)) bus ();

  tank_bullet_pool #(.NUM_BULLETS(NB)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------- reference model
  int         m_tx, m_ty, m_cd;
  logic [3:0] m_dir;
  bit         m_prev, m_fe;
  bit         m_act [NB];
  int         m_bx  [NB];
  int         m_by  [NB];
  logic [3:0] m_bdir[NB];

  function automatic int dxo(input logic [3:0] d);
    return d[3] ? 1 : (d[2] ? -1 : 0);
  endfunction

  function automatic int dyo(input logic [3:0] d);
    return d[1] ? 1 : (d[0] ? -1 : 0);
  endfunction

  function automatic bit inb(input int x, input int y);
    return x >= XMIN && x <= XMAX && y >= YMIN && y <= YMAX;
  endfunction

  function automatic logic [3:0] key_dir(input logic [7:0] k);
    case (k)
      8'h1A:   return 4'b0001;
      8'h16:   return 4'b0010;
      8'h04:   return 4'b0100;
      8'h07:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_tx = 320; m_ty = 240; m_dir = 4'b0001; m_cd = 0; m_prev = 1'b1; m_fe = 1'b0;
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 1'b0; m_bx[i] = 0; m_by[i] = 0; m_bdir[i] = 4'b0001;
    end
  endtask

  task automatic model_step(input logic [7:0] key, input logic [NB-1:0] hit);
    int slot, sx, sy, nx, ny;
    bit fire, accept;
    logic [3:0] kd;
    fire   = (key == 8'h2C) && !m_prev;
    m_prev = (key == 8'h2C);
    slot = -1;
    for (int i = NB - 1; i >= 0; i--) if (!m_act[i]) slot = i;
    // Bullet emerges 20 px beyond the tank centre offset along the facing.
    sx = m_tx + 12 + 20 * dxo(m_dir);
    sy = m_ty + 12 + 20 * dyo(m_dir);
    accept = fire && (m_cd == 0) && (slot >= 0) && inb(sx, sy);
    for (int i = 0; i < NB; i++) begin
      if (m_act[i]) begin
        if (hit[i]) m_act[i] = 1'b0;
        else begin
          nx = m_bx[i] + 4 * dxo(m_bdir[i]);
          ny = m_by[i] + 4 * dyo(m_bdir[i]);
          if (inb(nx, ny)) begin m_bx[i] = nx; m_by[i] = ny; end
          else m_act[i] = 1'b0;
        end
      end
    end
    if (accept) begin
      m_act[slot] = 1'b1; m_bx[slot] = sx; m_by[slot] = sy; m_bdir[slot] = m_dir;
    end
    m_cd = accept ? 8 : (m_cd > 0 ? m_cd - 1 : 0);
    kd = key_dir(key);
    if (kd != 4'b0000) begin
      m_dir = kd;
      nx = m_tx + 2 * dxo(kd);
      ny = m_ty + 2 * dyo(kd);
      if (inb(nx, ny)) begin m_tx = nx; m_ty = ny; end
    end
    m_fe = accept;
  endtask

  // ---------------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [10*NB-1:0] ex, ey;
    logic [4*NB-1:0]  ed;
    logic [NB-1:0]    ea;
    for (int i = 0; i < NB; i++) begin
      ea[i]          = m_act[i];
      ex[10*i +: 10] = 10'(m_bx[i]);
      ey[10*i +: 10] = 10'(m_by[i]);
      ed[4*i +: 4]   = m_bdir[i];
    end
    chk("tank_x", bus.tank_x, 10'(m_tx));
    chk("tank_y", bus.tank_y, 10'(m_ty));
    chk("tank_dir", bus.tank_dir, m_dir);
    chk("fire_event", bus.fire_event, m_fe);
    chk("bullet_active", bus.bullet_active, ea);
    chk("bullet_x", bus.bullet_x, ex);
    chk("bullet_y", bus.bullet_y, ey);
    chk("bullet_dir", bus.bullet_dir, ed);
  endtask

  task automatic frame(input logic [7:0] key, input logic [NB-1:0] hit);
    bus.keycode   = key;
    bus.hit_clear = hit;
    model_step(key, hit);
    @(posedge frame_clk);
    #1;
    check_all();
  endtask

  task automatic do_reset(input logic [7:0] key, input logic [NB-1:0] hit);
    Reset         = 1'b1;
    bus.keycode   = key;
    bus.hit_clear = hit;
    model_reset();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    check_all();
  endtask

  logic [7:0] keys [8] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h2C, 8'h00, 8'h55};

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [7:0]    key;
    logic [NB-1:0] hit;
    bus.keycode   = 8'h00;
    bus.hit_clear = '0;

    // Reset values
    do_reset(8'h00, '0);
    chk("rst_tank_x", bus.tank_x, 10'd320);
    chk("rst_tank_y", bus.tank_y, 10'd240);
    chk("rst_tank_dir", bus.tank_dir, 4'b0001);
    chk("rst_active", bus.bullet_active, 4'h0);
    chk("rst_bullet_dir", bus.bullet_dir, 16'h1111);
    chk("rst_bullet_y", bus.bullet_y, 40'h0);

    // Three frames of up
    repeat (3) frame(8'h1A, '0);
    chk("up3_tank_y", bus.tank_y, 10'd234);
    chk("up3_tank_dir", bus.tank_dir, 4'b0001);

    // Drive into the left wall and keep pushing
    repeat (125) frame(8'h04, '0);
    chk("wall_tank_x", bus.tank_x, 10'd80);
    chk("wall_tank_dir", bus.tank_dir, 4'b0100);

    // Facing left at the wall: spawn x=72 is off-field, shot rejected
    frame(8'h00, '0);
    frame(8'h2C, '0);
    chk("offfield_fire_event", bus.fire_event, 1'b0);
    chk("offfield_active", bus.bullet_active, 4'h0);

    // Reset with fire held and kills requested; held key must not shoot afterwards
    do_reset(8'h2C, '1);
    frame(8'h2C, '0);
    chk("held_after_reset_fire_event", bus.fire_event, 1'b0);
    frame(8'h00, '0);

    // Five taps nine frames apart: four fill the pool, the fifth is rejected
    for (int t = 0; t < 5; t++) begin
      frame(8'h2C, '0);
      chk("tap_fire_event", bus.fire_event, (t < 4) ? 1'b1 : 1'b0);
      if (t == 0) begin
        chk("spawn_y", bus.bullet_y[9:0], 10'd232);
        frame(8'h00, '0);
        chk("fly_y_228", bus.bullet_y[9:0], 10'd228);
        frame(8'h00, '0);
        chk("fly_y_224", bus.bullet_y[9:0], 10'd224);
        repeat (6) frame(8'h00, '0);
      end else begin
        repeat (8) frame(8'h00, '0);
      end
    end
    chk("pool_full", bus.bullet_active, 4'hF);

    // Kill slot 0 in the same frame as a shot: freed slot not reusable yet
    frame(8'h2C, 4'b0001);
    chk("hit_same_frame_fire_event", bus.fire_event, 1'b0);
    chk("hit_same_frame_active", bus.bullet_active, 4'b1110);
    frame(8'h00, '0);
    frame(8'h2C, '0);
    chk("retry_fire_event", bus.fire_event, 1'b1);
    chk("retry_active", bus.bullet_active, 4'hF);
    chk("retry_slot0_y", bus.bullet_y[9:0], 10'd232);

    // Two taps three frames apart: cooldown rejects the second
    do_reset(8'h00, '0);
    frame(8'h00, '0);
    frame(8'h2C, '0);
    chk("cd_first_fire_event", bus.fire_event, 1'b1);
    frame(8'h00, '0);
    frame(8'h00, '0);
    frame(8'h2C, '0);
    chk("cd_second_fire_event", bus.fire_event, 1'b0);
    chk("cd_active", bus.bullet_active, 4'b0001);

    // Let the upward bullet fly out: 232 -> 0 in 58 moves, cleared on the 59th frame
    cnt = 0;
    while (bus.bullet_active[0] && cnt < 100) begin
      frame(8'h00, '0);
      cnt++;
    end
    chk("clear_frame_count", 32'(cnt), 32'd56);
    chk("clear_last_y", bus.bullet_y[9:0], 10'd0);
    frame(8'h2C, '0);
    chk("reuse_fire_event", bus.fire_event, 1'b1);
    chk("reuse_active", bus.bullet_active, 4'b0001);

    // Random traffic, with one reset landing on a held fire and kills
    do_reset(8'h00, '0);
    for (int n = 0; n < 400; n++) begin
      key = keys[$urandom_range(0, 7)];
      hit = ($urandom_range(0, 7) == 0) ? NB'($urandom) : '0;
      if (n == 200) do_reset(8'h2C, '1);
      else frame(key, hit);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tank_bullet_pool.md
TANK_BULLET_POOL -- requirements
Module: tank_bullet_pool

Interface
REQ-001 SHALL have parameter NUM_BULLETS, 4, bullet slots (1..8).
REQ-002 SHALL have parameter STEP, 2, tank pixels moved per frame.
REQ-003 SHALL have parameter BULLET_SPEED, 4, bullet pixels moved per frame.
REQ-004 SHALL have parameter COOLDOWN, 8, minimum frames between accepted shots.
REQ-005 SHALL have parameters X_MIN 80, X_MAX 527, Y_MIN 0, Y_MAX 447, the playfield bounds for tank top-left and bullet position.
REQ-006 SHALL have parameters X_RESET 320, Y_RESET 240, the tank reset position.
REQ-007 SHALL have port frame_clk  in  1  clock, one edge per video frame.
REQ-008 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have port keycode  in  8  key code: 0x1A up, 0x16 down, 0x04 left, 0x07 right, 0x2C fire.
REQ-010 SHALL have port hit_clear  in  NUM_BULLETS  per-slot kill request from external collision logic.
REQ-011 SHALL have port tank_x, tank_y  out  10 each  tank top-left position.
REQ-012 SHALL have port tank_dir  out  4  one-hot facing: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-013 SHALL have port bullet_active  out  NUM_BULLETS  per-slot valid.
REQ-014 SHALL have ports bullet_x, bullet_y  out  10*NUM_BULLETS each, slot i in bits [10i+9:10i].
REQ-015 SHALL have port bullet_dir  out  4*NUM_BULLETS  per-slot one-hot direction.
REQ-016 SHALL have port fire_event  out  1  one-frame pulse when a shot is accepted.

Function
REQ-017 SHALL update tank_dir for any direction key, even when movement is blocked.
REQ-018 SHALL move the tank STEP in the key direction only if the result stays within [X_MIN,X_MAX] / [Y_MIN,Y_MAX]; otherwise the position holds.
REQ-019 SHALL treat all other keycodes as no movement.
REQ-020 SHALL detect fire as keycode==0x2C this frame and !=0x2C on the previous frame (rising edge).
REQ-021 SHALL accept a fire only when the cooldown counter is 0 and at least one slot is free.
REQ-022 SHALL load the cooldown counter with COOLDOWN on acceptance and decrement it once per frame, saturating at 0.
REQ-023 SHALL discard a rejected fire (no pool slot or cooldown nonzero), leaving the cooldown counter unchanged; it SHALL NOT be queued.
REQ-024 SHALL place an accepted shot in the lowest-index inactive slot.
REQ-025 SHALL spawn from the pre-move tank position: up (x+12, y-8), down (x+12, y+32), left (x-8, y+12), right (x+32, y+12); dir = tank_dir.
REQ-026 SHALL, if the spawn point is outside bounds, reject the shot with no slot taken, no cooldown load and no fire_event.
REQ-027 SHALL move each active bullet by BULLET_SPEED along its direction per frame.
REQ-028 SHALL clear a slot instead of moving it when the next position would leave bounds, using unsigned-safe comparison without underflow wrap.
REQ-029 SHALL clear slot i on hit_clear[i]; this overrides movement.
REQ-030 SHALL NOT reuse a slot freed in frame N before frame N+1.
REQ-031 SHALL assert fire_event for exactly the frame after acceptance; bullet outputs reflect the new slot in that same frame.
REQ-032 SHALL ignore hit_clear for inactive slots.

Reset
REQ-033 SHALL set on Reset: tank_x=X_RESET, tank_y=Y_RESET, tank_dir=0001, all bullet_active=0, bullet_x/y=0, bullet_dir=0001, cooldown=0, fire_event=0, prev-fire=1 (held fire key does not shoot after reset).
REQ-034 SHALL have Reset override all activity, including a bullet in flight or a same-frame fire.

Configuration
REQ-035 SHALL, with TANK_AUTOFIRE_EN defined, treat a held 0x2C as a fire request every frame, so shots repeat each time the cooldown expires and a slot is free.
REQ-036 SHALL, with TANK_AUTOFIRE_EN undefined, accept only rising-edge fire per REQ-020.

Verification
REQ-037 SHALL verify: Reset, then 0x1A for 3 frames -> tank_y=234, tank_dir=0001.
REQ-038 SHALL verify: tank at x=80 with 0x04 held -> tank_x stays 80, tank_dir=0100.
REQ-039 SHALL verify: fire tapped 5 times, 9 frames apart, with 4 slots -> slots 0..3 active, 5th rejected, no fire_event.
REQ-040 SHALL verify: fire tapped twice 3 frames apart -> only first accepted (COOLDOWN=8).
REQ-041 SHALL verify: bullet up from tank_y=240 -> spawn y=232, then 228, 224 ...; cleared the frame before y<0; slot reusable next frame.
REQ-042 SHALL verify: hit_clear[0] in the same frame as fire with slot 0 the only free slot -> slot 0 cleared, fire rejected; retry next frame allocates slot 0.
